// File: rtl/traffic_phase_scheduler.sv
// Signalised intersection controller: NS/EW green-yellow-allred cycle with an
// exclusive pedestrian phase and north-south emergency preemption.
module traffic_phase_scheduler #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       veh_ew,
  input  logic       ped_req,
  input  logic       emerg_ns,
  output logic [2:0] NS,
  output logic [2:0] EW,
  output logic       walk,
  output logic [2:0] phase,
  output logic       ped_pend
);

  localparam logic [2:0] S_NS_G  = 3'd0;
  localparam logic [2:0] S_NS_Y  = 3'd1;
  localparam logic [2:0] S_AR_NS = 3'd2;
  localparam logic [2:0] S_EW_G  = 3'd3;
  localparam logic [2:0] S_EW_Y  = 3'd4;
  localparam logic [2:0] S_AR_EW = 3'd5;
  localparam logic [2:0] S_PED   = 3'd6;

  // Timer values on the last cycle of each timed interval.
  localparam logic [7:0] GMIN_LAST   = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GMAX_LAST   = 8'(GREEN_MAX - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_T - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_T - 1);
  localparam logic [7:0] WALK_LAST   = 8'(WALK_T - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       ped_pend_q, ped_pend_d;
  logic       from_ns_q, from_ns_d;

  always_comb begin
    state_d   = state_q;
    from_ns_d = from_ns_q;
    case (state_q)
      S_NS_G: begin
        if (!emerg_ns && (timer_q >= GMIN_LAST) && (veh_ew || ped_pend_q))
          state_d = S_NS_Y;
      end
      S_NS_Y: begin
        if (timer_q == YELLOW_LAST) state_d = S_AR_NS;
      end
      S_AR_NS: begin
        if (timer_q == ALLRED_LAST) begin
          if (ped_pend_q) begin
            state_d   = S_PED;
            from_ns_d = 1'b1;
          end else begin
            state_d = S_EW_G;
          end
        end
      end
      S_EW_G: begin
        if (emerg_ns || ((timer_q >= GMIN_LAST) && !veh_ew) || (timer_q == GMAX_LAST))
          state_d = S_EW_Y;
      end
      S_EW_Y: begin
        if (timer_q == YELLOW_LAST) state_d = S_AR_EW;
      end
      S_AR_EW: begin
        if (timer_q == ALLRED_LAST) begin
          if (ped_pend_q) begin
            state_d   = S_PED;
            from_ns_d = 1'b0;
          end else begin
            state_d = S_NS_G;
          end
        end
      end
      S_PED: begin
        // Emergency at walk exit always hands right of way to north-south.
        if (timer_q == WALK_LAST)
          state_d = (from_ns_q && !emerg_ns) ? S_EW_G : S_NS_G;
      end
      default: state_d = S_NS_G;
    endcase

    if (state_d != state_q)
      timer_d = 8'd0;
    else if (timer_q != 8'hFF)
      timer_d = timer_q + 8'd1;
    else
      timer_d = timer_q;

    if ((state_d == S_PED) && (state_q != S_PED))
      ped_pend_d = 1'b0;
    else if (ped_req && (state_q != S_PED))
      ped_pend_d = 1'b1;
    else
      ped_pend_d = ped_pend_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_NS_G;
      timer_q    <= 8'd0;
      ped_pend_q <= 1'b0;
      from_ns_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
      from_ns_q  <= from_ns_d;
    end
  end

  // Lamp order is {Red,Yellow,Green}; anything unexpected shows red both ways.
  always_comb begin
    NS = 3'b100;
    EW = 3'b100;
    case (state_q)
      S_NS_G: NS = 3'b001;
      S_NS_Y: NS = 3'b010;
      S_EW_G: EW = 3'b001;
      S_EW_Y: EW = 3'b010;
      default: ;
    endcase
  end

  assign walk     = (state_q == S_PED);
  assign phase    = state_q;
  assign ped_pend = ped_pend_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed-vector bench for traffic_phase_scheduler at default parameters.
module tb_traffic_phase_scheduler;

  localparam logic [2:0] P_NS_G  = 3'd0;
  localparam logic [2:0] P_NS_Y  = 3'd1;
  localparam logic [2:0] P_AR_NS = 3'd2;
  localparam logic [2:0] P_EW_G  = 3'd3;
  localparam logic [2:0] P_EW_Y  = 3'd4;
  localparam logic [2:0] P_AR_EW = 3'd5;
  localparam logic [2:0] P_PED   = 3'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       veh_ew = 1'b0;
  logic       ped_req = 1'b0;
  logic       emerg_ns = 1'b0;
  logic [2:0] NS, EW, phase;
  logic       walk, ped_pend;

  int n_vec = 0;
  int n_err = 0;

  traffic_phase_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .veh_ew   (veh_ew),
    .ped_req  (ped_req),
    .emerg_ns (emerg_ns),
    .NS       (NS),
    .EW       (EW),
    .walk     (walk),
    .phase    (phase),
    .ped_pend (ped_pend)
  );

  always #5 clk = ~clk;

  // Packed view: {ped_pend, walk, NS, EW, phase}
  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h required %h", tag, $time, got, exp);
    end
  endtask

  // Lamp table {walk, NS, EW} for each phase.
  function automatic logic [6:0] lamps(input logic [2:0] ph);
    case (ph)
      P_NS_G:  lamps = {1'b0, 3'b001, 3'b100};
      P_NS_Y:  lamps = {1'b0, 3'b010, 3'b100};
      P_EW_G:  lamps = {1'b0, 3'b100, 3'b001};
      P_EW_Y:  lamps = {1'b0, 3'b100, 3'b010};
      P_PED:   lamps = {1'b1, 3'b100, 3'b100};
      default: lamps = {1'b0, 3'b100, 3'b100};
    endcase
  endfunction

  function automatic logic [10:0] observed();
    observed = {ped_pend, walk, NS, EW, phase};
  endfunction

  // Check n consecutive cycles against one phase/pending value, then advance.
  task automatic expect_cyc(input string tag, input logic [2:0] ph, input logic pend, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, observed(), {pend, lamps(ph), ph});
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench one tick after an edge with reset just released: cycle 0.
  task automatic do_reset();
    rst      = 1'b1;
    veh_ew   = 1'b0;
    ped_req  = 1'b0;
    emerg_ns = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", observed(), {1'b0, lamps(P_NS_G), P_NS_G});
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Idle rest in NS green.
    do_reset();
    expect_cyc("idle_ns_g", P_NS_G, 1'b0, 30);
    $display("scenario idle done");

    // Continuous EW demand: EW green maxes out, cycle repeats.
    do_reset();
    veh_ew = 1'b1;
    expect_cyc("veh_ns_g",   P_NS_G,  1'b0, 4);
    expect_cyc("veh_ns_y",   P_NS_Y,  1'b0, 3);
    expect_cyc("veh_ar_ns",  P_AR_NS, 1'b0, 1);
    expect_cyc("veh_ew_max", P_EW_G,  1'b0, 8);
    expect_cyc("veh_ew_y",   P_EW_Y,  1'b0, 3);
    expect_cyc("veh_ar_ew",  P_AR_EW, 1'b0, 1);
    expect_cyc("veh_ns_g2",  P_NS_G,  1'b0, 4);
    expect_cyc("veh_ns_y2",  P_NS_Y,  1'b0, 3);
    expect_cyc("veh_ar_ns2", P_AR_NS, 1'b0, 1);
    expect_cyc("veh_ew_g2",  P_EW_G,  1'b0, 1);
    $display("scenario vehicle cycle done");

    // Pedestrian request at cycle 2, extra presses during walk are ignored.
    do_reset();
    expect_cyc("ped_ns_g",   P_NS_G,  1'b0, 2);
    ped_req = 1'b1;
    expect_cyc("ped_press",  P_NS_G,  1'b0, 1);
    ped_req = 1'b0;
    expect_cyc("ped_latch",  P_NS_G,  1'b1, 1);
    expect_cyc("ped_ns_y",   P_NS_Y,  1'b1, 3);
    expect_cyc("ped_ar_ns",  P_AR_NS, 1'b1, 1);
    expect_cyc("ped_walk0",  P_PED,   1'b0, 1);
    ped_req = 1'b1;
    expect_cyc("ped_walk1",  P_PED,   1'b0, 1);
    ped_req = 1'b0;
    expect_cyc("ped_walk2",  P_PED,   1'b0, 1);
    ped_req = 1'b1;
    expect_cyc("ped_walk3",  P_PED,   1'b0, 1);
    ped_req = 1'b0;
    expect_cyc("ped_walk4",  P_PED,   1'b0, 1);
    expect_cyc("ped_ew_min", P_EW_G,  1'b0, 4);
    expect_cyc("ped_ew_y",   P_EW_Y,  1'b0, 3);
    expect_cyc("ped_ar_ew",  P_AR_EW, 1'b0, 1);
    expect_cyc("ped_rest",   P_NS_G,  1'b0, 5);
    $display("scenario pedestrian done");

    // Emergency preempt two cycles into EW green.
    do_reset();
    veh_ew = 1'b1;
    expect_cyc("em_ns_g",    P_NS_G,  1'b0, 4);
    expect_cyc("em_ns_y",    P_NS_Y,  1'b0, 3);
    expect_cyc("em_ar_ns",   P_AR_NS, 1'b0, 1);
    expect_cyc("em_ew_g0",   P_EW_G,  1'b0, 1);
    emerg_ns = 1'b1;
    expect_cyc("em_ew_g1",   P_EW_G,  1'b0, 1);
    expect_cyc("em_ew_y",    P_EW_Y,  1'b0, 3);
    expect_cyc("em_ar_ew",   P_AR_EW, 1'b0, 1);
    expect_cyc("em_hold",    P_NS_G,  1'b0, 8);
    emerg_ns = 1'b0;
    expect_cyc("em_release", P_NS_G,  1'b0, 1);
    expect_cyc("em_ns_y2",   P_NS_Y,  1'b0, 1);
    $display("scenario emergency done");

    // Emergency at walk exit overrides return to EW green.
    do_reset();
    ped_req = 1'b1;
    expect_cyc("pe_press",   P_NS_G,  1'b0, 1);
    ped_req = 1'b0;
    expect_cyc("pe_ns_g",    P_NS_G,  1'b1, 3);
    expect_cyc("pe_ns_y",    P_NS_Y,  1'b1, 3);
    expect_cyc("pe_ar_ns",   P_AR_NS, 1'b1, 1);
    expect_cyc("pe_walk",    P_PED,   1'b0, 4);
    emerg_ns = 1'b1;
    expect_cyc("pe_walk_end", P_PED,  1'b0, 1);
    expect_cyc("pe_to_ns_g", P_NS_G,  1'b0, 3);
    emerg_ns = 1'b0;
    $display("scenario walk preempt done");

    // Asynchronous reset during EW yellow with a pending request.
    do_reset();
    veh_ew = 1'b1;
    expect_cyc("ar_ns_g",    P_NS_G,  1'b0, 4);
    expect_cyc("ar_ns_y",    P_NS_Y,  1'b0, 3);
    expect_cyc("ar_ar_ns",   P_AR_NS, 1'b0, 1);
    expect_cyc("ar_ew_g",    P_EW_G,  1'b0, 2);
    ped_req = 1'b1;
    expect_cyc("ar_press",   P_EW_G,  1'b0, 1);
    ped_req = 1'b0;
    expect_cyc("ar_ew_g_p",  P_EW_G,  1'b1, 5);
    expect_cyc("ar_ew_y",    P_EW_Y,  1'b1, 1);
    rst = 1'b1;
    #1;
    chk("rst_async", observed(), {1'b0, lamps(P_NS_G), P_NS_G});
    @(posedge clk);
    #1;
    chk("rst_held", observed(), {1'b0, lamps(P_NS_G), P_NS_G});
    rst = 1'b0;
    expect_cyc("ar_post_g",  P_NS_G,  1'b0, 4);
    expect_cyc("ar_post_y",  P_NS_Y,  1'b0, 1);
    $display("scenario reset mid-phase done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
